// File: rtl/icache_fetch.sv
// Direct-mapped instruction cache with one 32-bit word per line, refilled
// bytewise from memory. Define ICACHE_PERF_EN to enable the hit/miss counters.
module icache_fetch #(
    parameter int INDEX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        nd_ins,
    input  logic [31:0] pc_fetch,
    input  logic        flush,
    output logic        flg_get,
    output logic [31:0] ins_out,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_data,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 32 - INDEX_BITS - 2;

    typedef enum logic [1:0] {IDLE, REFILL, RESP} state_t;

    state_t                  state;
    logic [LINES-1:0]        valid;
    logic [31:0]             data_mem [LINES];
    logic [TAG_W-1:0]        tag_mem  [LINES];
    logic [31:0]             base_addr;
    logic [1:0]              cnt;
    logic [23:0]             byte_buf;

    logic [INDEX_BITS-1:0]   req_idx;
    logic [TAG_W-1:0]        req_tag;
    logic [INDEX_BITS-1:0]   fill_idx;
    logic [TAG_W-1:0]        fill_tag;
    logic [31:0]             fill_word;
    logic                    hit;
    logic                    take;
    logic                    fill_done;
    logic                    unused_pc_lsb;

    assign req_idx   = pc_fetch[INDEX_BITS+1:2];
    assign req_tag   = pc_fetch[31:INDEX_BITS+2];
    assign fill_idx  = base_addr[INDEX_BITS+1:2];
    assign fill_tag  = base_addr[31:INDEX_BITS+2];
    assign fill_word = {mem_data, byte_buf};
    assign hit       = valid[req_idx] && (tag_mem[req_idx] == req_tag);
    assign unused_pc_lsb = &{1'b0, pc_fetch[1:0]};

    // A request is only taken while running, idle, not flushing and not
    // presenting a result; anything else is simply dropped.
    assign take      = rdy && !flush && (state == IDLE) && nd_ins && !flg_get;
    assign fill_done = rdy && !flush && (state == REFILL) && mem_ack && (cnt == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            valid     <= '0;
            flg_get   <= 1'b0;
            mem_req   <= 1'b0;
            ins_out   <= '0;
            mem_addr  <= '0;
            base_addr <= '0;
            cnt       <= '0;
            byte_buf  <= '0;
        end else if (rdy) begin
            if (flush) begin
                state   <= IDLE;
                flg_get <= 1'b0;
                mem_req <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (take) begin
                            if (hit) begin
                                state   <= RESP;
                                flg_get <= 1'b1;
                                ins_out <= data_mem[req_idx];
                            end else begin
                                state     <= REFILL;
                                base_addr <= {pc_fetch[31:2], 2'b00};
                                mem_addr  <= {pc_fetch[31:2], 2'b00};
                                cnt       <= 2'd0;
                                mem_req   <= 1'b1;
                            end
                        end
                    end
                    REFILL: begin
                        if (mem_ack) begin
                            if (cnt == 2'd3) begin
                                valid[fill_idx] <= 1'b1;
                                state           <= RESP;
                                mem_req         <= 1'b0;
                                flg_get         <= 1'b1;
                                ins_out         <= fill_word;
                            end else begin
                                case (cnt)
                                    2'd0:    byte_buf[7:0]   <= mem_data;
                                    2'd1:    byte_buf[15:8]  <= mem_data;
                                    default: byte_buf[23:16] <= mem_data;
                                endcase
                                cnt      <= cnt + 2'd1;
                                mem_addr <= base_addr + 32'(cnt) + 32'd1;
                            end
                        end
                    end
                    RESP: begin
                        state   <= IDLE;
                        flg_get <= 1'b0;
                    end
                    default: begin
                        state   <= IDLE;
                        flg_get <= 1'b0;
                        mem_req <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Line storage carries no reset; the valid bits alone qualify it.
    always_ff @(posedge clk) begin
        if (!rst && fill_done) begin
            data_mem[fill_idx] <= fill_word;
            tag_mem[fill_idx]  <= fill_tag;
        end
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_q;
    logic [31:0] miss_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else if (take) begin
            if (hit) hit_q  <= hit_q + 32'd1;
            else     miss_q <= miss_q + 32'd1;
        end
    end

    assign hit_cnt  = hit_q;
    assign miss_cnt = miss_q;
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_icache_fetch.sv
// Directed self-checking bench for icache_fetch: cold miss, re-hit, conflict,
// flush, rdy stall and reset during refill.
module tb_icache_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        nd_ins;
    logic [31:0] pc_fetch;
    logic        flush;
    logic        flg_get;
    logic [31:0] ins_out;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_data;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    int n_assert = 0;
    int n_fail   = 0;

`ifdef ICACHE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    icache_fetch #(.INDEX_BITS(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .nd_ins   (nd_ins),
        .pc_fetch (pc_fetch),
        .flush    (flush),
        .flg_get  (flg_get),
        .ins_out  (ins_out),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .mem_data (mem_data),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input int hits, input int misses);
        chk({tag, "_hit_cnt"},  hit_cnt,  PERF ? 32'(hits)   : 32'd0);
        chk({tag, "_miss_cnt"}, miss_cnt, PERF ? 32'(misses) : 32'd0);
    endtask

    // Issue a request on the current cycle, then return one cycle later.
    task automatic request(input logic [31:0] pc);
        nd_ins   = 1'b1;
        pc_fetch = pc;
        tick();
        nd_ins   = 1'b0;
    endtask

    // One memory acknowledge carrying byte b.
    task automatic ack(input logic [7:0] b);
        mem_ack  = 1'b1;
        mem_data = b;
        tick();
        mem_ack  = 1'b0;
    endtask

    // Deliver bytes b[start..3] of a refill at base, checking address steps and the result pulse.
    task automatic fill(input string tag, input logic [31:0] base, input int start,
                        input logic [31:0] word);
        for (int i = start; i < 4; i++) begin
            chk({tag, "_mem_req"},  {31'd0, mem_req}, 32'd1);
            chk({tag, "_mem_addr"}, mem_addr, base + 32'(i));
            ack(word[8*i +: 8]);
        end
        chk({tag, "_flg_get"}, {31'd0, flg_get}, 32'd1);
        chk({tag, "_ins_out"}, ins_out, word);
        chk({tag, "_req_off"}, {31'd0, mem_req}, 32'd0);
        tick();
        chk({tag, "_flg_drop"}, {31'd0, flg_get}, 32'd0);
        chk({tag, "_ins_hold"}, ins_out, word);
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; nd_ins = 1'b0; pc_fetch = '0;
        flush = 1'b0; mem_ack = 1'b0; mem_data = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_flg_get", {31'd0, flg_get}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_ins_out", ins_out, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk_cnt("rst", 0, 0);

        // Cold miss at 0x10
        request(32'h10);
        chk("cold_flg", {31'd0, flg_get}, 32'd0);
        fill("cold", 32'h10, 0, 32'h00100513);

        // Re-hit: one-cycle latency, no memory traffic
        request(32'h10);
        chk("rehit_flg", {31'd0, flg_get}, 32'd1);
        chk("rehit_ins", ins_out, 32'h00100513);
        chk("rehit_req", {31'd0, mem_req}, 32'd0);
        tick();
        chk("rehit_drop", {31'd0, flg_get}, 32'd0);
        chk_cnt("rehit", 1, 1);

        // Conflict on index 4: 0x110 evicts 0x10, which then misses again
        request(32'h110);
        fill("conf_a", 32'h110, 0, 32'hDDCCBBAA);
        request(32'h10);
        fill("conf_b", 32'h10, 0, 32'h00100513);
        chk_cnt("conf", 1, 3);

        // Flush beats a same-cycle request
        nd_ins = 1'b1; pc_fetch = 32'h10; flush = 1'b1;
        tick();
        nd_ins = 1'b0; flush = 1'b0;
        chk("flprio_flg", {31'd0, flg_get}, 32'd0);
        tick();
        chk("flprio_flg2", {31'd0, flg_get}, 32'd0);
        chk_cnt("flprio", 1, 3);

        // Flush after two acks at 0x20; an ack in the flush cycle is dropped
        request(32'h20);
        ack(8'h11);
        ack(8'h22);
        chk("fl_mid_addr", mem_addr, 32'h22);
        flush = 1'b1; mem_ack = 1'b1; mem_data = 8'h33;
        tick();
        flush = 1'b0; mem_ack = 1'b0;
        chk("fl_req", {31'd0, mem_req}, 32'd0);
        chk("fl_flg", {31'd0, flg_get}, 32'd0);
        tick();
        chk("fl_flg2", {31'd0, flg_get}, 32'd0);
        request(32'h20);
        fill("fl_refill", 32'h20, 0, 32'h77665544);
        chk_cnt("fl", 1, 5);

        // Flush left other lines valid
        request(32'h10);
        chk("keep_flg", {31'd0, flg_get}, 32'd1);
        chk("keep_ins", ins_out, 32'h00100513);
        chk("keep_req", {31'd0, mem_req}, 32'd0);
        tick();

        // rdy stall mid-refill with mem_ack pulsed
        request(32'h30);
        ack(8'h01);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ack(8'hEE);
            chk("stall_addr", mem_addr, 32'h31);
            chk("stall_req", {31'd0, mem_req}, 32'd1);
            chk("stall_flg", {31'd0, flg_get}, 32'd0);
        end
        rdy = 1'b1;
        fill("stall", 32'h30, 1, 32'h04030201);
        chk_cnt("stall", 2, 6);

        // Reset mid-refill discards the partial line and the cache contents
        request(32'h40);
        ack(8'h99);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rmid_req", {31'd0, mem_req}, 32'd0);
        chk("rmid_addr", mem_addr, 32'd0);
        chk("rmid_ins", ins_out, 32'd0);
        chk("rmid_flg", {31'd0, flg_get}, 32'd0);
        chk_cnt("rmid", 0, 0);
        request(32'h40);
        chk("rmid_miss_flg", {31'd0, flg_get}, 32'd0);
        fill("rmid_refill", 32'h40, 0, 32'hA1B2C3D4);
        request(32'h10);
        chk("rmid_inval_flg", {31'd0, flg_get}, 32'd0);
        chk("rmid_inval_req", {31'd0, mem_req}, 32'd1);
        chk_cnt("rmid_end", 0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/icache_fetch.md
ICACHE_FETCH -- requirements
Module: icache_fetch

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 6, meaning log2 of line count; lines are one 32-bit word each.
REQ-002 SHALL have port clk input 1, system clock.
REQ-003 SHALL have port rst input 1, reset, synchronous, active-high.
REQ-004 SHALL have port rdy input 1; when low, all state holds.
REQ-005 SHALL have port nd_ins input 1, fetch request from the fetch stage.
REQ-006 SHALL have port pc_fetch input 32, word-aligned fetch address.
REQ-007 SHALL have port flush input 1, which aborts the outstanding fetch (jump redirect).
REQ-008 SHALL have port flg_get output 1, a one-cycle pulse marking ins_out valid.
REQ-009 SHALL have port ins_out output 32, the fetched instruction.
REQ-010 SHALL have port mem_req output 1, a byte read request to the memory controller.
REQ-011 SHALL have port mem_addr output 32, the byte address of the read.
REQ-012 SHALL have port mem_ack input 1, pulsed by the memory controller when mem_data is valid.
REQ-013 SHALL have port mem_data input 8, the returned byte.
REQ-014 SHALL have port hit_cnt output 32, the hit counter.
REQ-015 SHALL have port miss_cnt output 32, the miss counter.

Function
REQ-016 SHALL decode each address as index = pc_fetch[INDEX_BITS+1:2] and tag = pc_fetch[31:INDEX_BITS+2].
REQ-017 SHALL implement states IDLE, REFILL and RESP.
REQ-018 SHALL accept a request in IDLE only, when nd_ins=1 and flg_get=0; other requests are ignored.
REQ-019 SHALL, on a hit (valid and tag match) in IDLE, go to RESP, drive the line onto ins_out and pulse flg_get on the next cycle (1-cycle latency), then return to IDLE.
REQ-020 SHALL, on a miss in IDLE, latch the address, clear the byte count to 0 and go to REFILL.
REQ-021 SHALL, in REFILL, hold mem_req=1 with mem_addr = latched address + byte count; each mem_ack stores mem_data at byte[8*cnt+7:8*cnt] (little-endian) and increments the count.
REQ-022 SHALL, on the 4th mem_ack, write data, tag and valid into the line, drop mem_req and go to RESP; flg_get then pulses with the assembled word exactly one cycle after the 4th ack.
REQ-023 SHALL hold mem_req=0 outside REFILL.
REQ-024 SHALL, on flush in any state, go to IDLE next cycle with no flg_get, mem_req=0 and no line write; a mem_ack in the same cycle is discarded.
REQ-025 SHALL NOT invalidate lines on flush.
REQ-026 SHALL give flush priority over a new request in the same cycle; the request is not accepted.
REQ-027 SHALL, when rdy=0, freeze state, counters and outputs; mem_ack is ignored while rdy=0.
REQ-028 SHALL hold ins_out at its last value when flg_get=0.

Reset
REQ-029 SHALL, on rst, enter IDLE, clear all valid bits, and set flg_get=0, mem_req=0, ins_out=0, mem_addr=0, hit_cnt=0, miss_cnt=0.
REQ-030 SHALL let rst override rdy and flush, including mid-REFILL; the partial line is discarded.

Configuration
REQ-031 SHALL, with macro ICACHE_PERF_EN defined, increment hit_cnt on each accepted hit and miss_cnt on each accepted miss; both counters wrap modulo 2^32.
REQ-032 SHALL, without ICACHE_PERF_EN, tie hit_cnt and miss_cnt to 0 with no counter logic; all other behaviour is unchanged.

Verification
REQ-033 SHALL cover a cold miss: request pc=0x00000010, memory bytes 0x13,0x05,0x10,0x00 acked over 4 cycles -> mem_addr steps 0x10..0x13, flg_get pulses with ins_out=0x00100513 one cycle after the last ack.
REQ-034 SHALL cover a re-hit: request pc=0x10 again -> no mem_req, flg_get one cycle later with ins_out=0x00100513; with ICACHE_PERF_EN, hit_cnt=1 and miss_cnt=1.
REQ-035 SHALL cover a conflict: pc=0x110 (same index, INDEX_BITS=6), then pc=0x10 -> both miss and refill; miss_cnt increments twice.
REQ-036 SHALL cover flush mid-refill: flush after 2 acks at pc=0x20 -> IDLE, no flg_get; a following request at pc=0x20 misses and issues 4 fresh reads from 0x20.
REQ-037 SHALL cover a rdy stall: rdy=0 for 3 cycles during REFILL with mem_ack pulsed -> byte count unchanged; the refill completes correctly after rdy returns high.
REQ-038 SHALL cover reset mid-refill: rst during REFILL -> all outputs 0 next cycle; a re-request at the same pc misses.
